mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to finish MULT/MULTU in a single CALC cycle with a combinational product.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state | meaning
    // IDLE  | waiting for start; mthi/mtlo writes accepted
    // CALC  | one multiply/divide iteration per cycle
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        is_div_q;
    logic        neg_q;
    logic        rneg_q;
    logic        dz_q;
    logic [31:0] mcand_q;
    logic [63:0] acc_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        sgn_d;
    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_step;
    logic        fast_mul;
    logic [63:0] iter_d;
    logic        last_d;
    logic [63:0] prod_fix;
    logic [31:0] res_hi_d;
    logic [31:0] res_lo_d;

    // Operand magnitudes; signed ops iterate on these and fix signs at the end
    always_comb begin
        sgn_d   = ~op[0];
        a_neg_d = sgn_d & a[31];
        b_neg_d = sgn_d & b[31];
        mag_a_d = a_neg_d ? (32'd0 - a) : a;
        mag_b_d = b_neg_d ? (32'd0 - b) : b;
    end

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};
        div_rem  = acc_q[63:31];
        div_ge   = (div_rem >= {1'b0, mcand_q});
        div_diff = div_rem[31:0] - mcand_q;
        div_step = {(div_ge ? div_diff : div_rem[31:0]), acc_q[30:0], div_ge};
`ifdef MDU_FAST_MUL_EN
        fast_mul = ~is_div_q;
        iter_d   = is_div_q ? div_step : ({32'd0, mcand_q} * {32'd0, acc_q[31:0]});
`else
        fast_mul = 1'b0;
        iter_d   = is_div_q ? div_step : mul_step;
`endif
        last_d   = (cnt_q == 6'd1) | fast_mul;
    end

    // A zero divisor still yields remainder = dividend; only the quotient is forced
    always_comb begin
        prod_fix = neg_q ? (64'd0 - iter_d) : iter_d;
        if (is_div_q) begin
            res_lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - iter_d[31:0]) : iter_d[31:0]);
            res_hi_d = rneg_q ? (32'd0 - iter_d[63:32]) : iter_d[63:32];
        end else begin
            res_lo_d = prod_fix[31:0];
            res_hi_d = prod_fix[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            mcand_q  <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= CALC;
                        cnt_q    <= 6'd32;
                        is_div_q <= op[1];
                        neg_q    <= a_neg_d ^ b_neg_d;
                        rneg_q   <= op[1] & a_neg_d;
                        dz_q     <= op[1] & (b == 32'd0);
                        mcand_q  <= op[1] ? mag_b_d : mag_a_d;
                        acc_q    <= {32'd0, (op[1] ? mag_a_d : mag_b_d)};
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                CALC: begin
                    acc_q <= iter_d;
                    if (last_d) begin
                        state_q <= IDLE;
                        cnt_q   <= 6'd0;
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CALC);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
